// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the button conditioner.
//   TICK_DIV_DEF     : default clk cycles per debounce sample tick
//   STABLE_TICKS_DEF : default ticks a new value must persist before acceptance
//   cnt_width()      : debounce counter width, clog2 with a floor of 1 bit
package btn_cond_pkg;

  localparam int unsigned TICK_DIV_DEF     = 1000;
  localparam int unsigned STABLE_TICKS_DEF = 10;

  // A single-tick debounce still needs a 1-bit counter to keep ports legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single input channel: 2-FF synchroniser, tick-driven debounce counter,
// debounced level, registered rise/fall pulses and optional push-on/push-off latch.
// Optional feature macro: BTN_COND_TOGGLE_EN (toggle flop; otherwise toggle = 0).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   ena        : enable; when low the debounce state freezes (sync keeps sampling)
//   tick       : shared prescaler sample strobe (already qualified by ena)
//   din        : raw asynchronous input
//   level      : debounced level
//   rise, fall : one-cycle pulses coincident with the first cycle of a new level
//   toggle     : inverts the cycle after each rise pulse
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned    CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept_c;

  // Last tick of a qualification window while the input still disagrees.
  assign accept_c = tick && (sync2 != level) && (cnt == CNT_LAST);

  // Metastability chain; samples regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Debounce counter: any return to the current level restarts the attempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (sync2 == level) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  // Level and edge pulses update on the same edge so the pulse marks the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept_c &&  sync2;
      fall <= accept_c && !sync2;
      if (accept_c) begin
        level <= sync2;
      end
    end
  end

`ifdef BTN_COND_TOGGLE_EN
  logic toggle_q;

  // Push-on/push-off latch driven by the registered rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
    end else if (rise) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Input conditioning for raw pad buttons: shared sample-tick prescaler plus
// WIDTH independent debounce channels.
// Optional feature macro: BTN_COND_TOGGLE_EN (per-channel toggle latch).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   ena        : design enable; low freezes prescaler and debounce state
//   din        : raw asynchronous inputs [WIDTH]
//   level      : debounced levels [WIDTH]
//   rise, fall : one-cycle edge pulses [WIDTH]
//   toggle     : push-on/push-off latches, 0 when the feature is off [WIDTH]
//   tick       : prescaler tick, decoded from the prescaler register
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] toggle,
  output logic             tick
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = ena && (presc == PRESC_LAST);

  // Free-running sample prescaler, paused while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ena) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .tick  (tick),
      .din   (din[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .toggle(toggle[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with WIDTH=4, TICK_DIV=4, STABLE_TICKS=3.
// Optional feature macro: BTN_COND_TOGGLE_EN changes expected toggle values.
module tb_btn_conditioner;

  localparam int unsigned W  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;

`ifdef BTN_COND_TOGGLE_EN
  localparam logic [W-1:0] TOG_A = 4'b1100;
  localparam logic [W-1:0] TOG_B = 4'b0100;
`else
  localparam logic [W-1:0] TOG_A = 4'b0000;
  localparam logic [W-1:0] TOG_B = 4'b0000;
`endif

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] bounce;
    logic         ena;
    int           cycles;
    logic [W-1:0] exp_level;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
    int           exp_ticks;
  } row_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] din;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] toggle;
  logic         tick;

  always #5 clk = ~clk;

  btn_conditioner #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .toggle(toggle),
    .tick  (tick)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rc[W];
  int   fc[W];
  int   tc;
  row_t rows[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < int'(W); i++) begin
      rc[i] = 0;
      fc[i] = 0;
    end
    tc = 0;
  endtask

  task automatic sample();
    for (int i = 0; i < int'(W); i++) begin
      rc[i] += int'(rise[i]);
      fc[i] += int'(fall[i]);
    end
    tc += int'(tick);
    chk("rise_fall_exclusive", 32'(rise & fall), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic wait_level(input string name, input logic [W-1:0] mask,
                            input logic [W-1:0] target, input int maxc, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < maxc) begin
      step();
      n++;
      if ((level & mask) == target) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles level=%b required=%b", name, maxc,
               level & mask, target);
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    clear_counts();
    ena = r.ena;
    for (int c = 0; c < r.cycles; c++) begin
      din = (((c / 2) % 2) == 1) ? (r.din ^ r.bounce) : r.din;
      step();
    end
    chk($sformatf("row%0d_level", idx), 32'(level), 32'(r.exp_level));
    for (int i = 0; i < int'(W); i++) begin
      chk($sformatf("row%0d_rise_count_bit%0d", idx, i), 32'(rc[i]), 32'(r.exp_rise[i]));
      chk($sformatf("row%0d_fall_count_bit%0d", idx, i), 32'(fc[i]), 32'(r.exp_fall[i]));
    end
    if (r.exp_ticks >= 0) chk($sformatf("row%0d_ticks", idx), 32'(tc), 32'(r.exp_ticks));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    //        din      bounce   ena   cyc  level    rise     fall     ticks
    rows[0] = '{4'b0011, 4'b0000, 1'b1, 5,   4'b0001, 4'b0000, 4'b0000, -1};
    rows[1] = '{4'b0001, 4'b0000, 1'b1, 10,  4'b0001, 4'b0000, 4'b0000, -1};
    rows[2] = '{4'b0011, 4'b0010, 1'b1, 40,  4'b0001, 4'b0000, 4'b0000, 10};
    rows[3] = '{4'b0011, 4'b0000, 1'b1, 20,  4'b0011, 4'b0010, 4'b0000, 5};
    rows[4] = '{4'b0000, 4'b0000, 1'b1, 20,  4'b0000, 4'b0000, 4'b0011, 5};
    rows[5] = '{4'b0100, 4'b0000, 1'b0, 100, 4'b0000, 4'b0000, 4'b0000, 0};

    rst_n = 1'b0;
    ena   = 1'b1;
    din   = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;

    // Idle after reset: outputs quiet, tick on cycles 3, 7, 11, 15, 19.
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      else sample();
      chk($sformatf("idle_tick_c%0d", k), 32'(tick),
          32'(k == 3 || k == 7 || k == 11 || k == 15 || k == 19));
      chk($sformatf("idle_outs_c%0d", k), 32'({level, rise, fall, toggle}), 32'(0));
    end

    // Single press on bit 0 at cycle 20.
    step();
    din = 4'b0001;
    wait_level("d0_qualify", 4'b0001, 4'b0001, 20, ok);
    if (ok) begin
      chk("d0_window", 32'(cyc >= 31 && cyc <= 34), 32'(1));
      chk("d0_level", 32'(level), 32'(4'b0001));
      chk("d0_rise", 32'(rise), 32'(4'b0001));
      chk("d0_fall", 32'(fall), 32'(4'b0000));
      step();
      chk("d0_rise_single", 32'(rise), 32'(4'b0000));
      chk("d0_level_hold", 32'(level), 32'(4'b0001));
    end

    // Glitch, bounce, steady press and release on bit 1.
    for (int r = 0; r < 5; r++) run_row(r, rows[r]);

    // All channels together.
    din = 4'b1111;
    wait_level("all_rise_wait", 4'b0001, 4'b0001, 20, ok);
    if (ok) begin
      chk("all_rise_level", 32'(level), 32'(4'b1111));
      chk("all_rise_pulse", 32'(rise), 32'(4'b1111));
      step();
      chk("all_rise_single", 32'(rise), 32'(4'b0000));
    end
    din = 4'b0000;
    wait_level("all_fall_wait", 4'b0001, 4'b0000, 20, ok);
    if (ok) begin
      chk("all_fall_level", 32'(level), 32'(4'b0000));
      chk("all_fall_pulse", 32'(fall), 32'(4'b1111));
      step();
      chk("all_fall_single", 32'(fall), 32'(4'b0000));
    end

    // Disabled: input held high must not qualify, then qualifies once enabled.
    run_row(5, rows[5]);
    ena = 1'b1;
    wait_level("ena_resume", 4'b0100, 4'b0100, 14, ok);
    if (ok) chk("ena_resume_rise", 32'(rise), 32'(4'b0100));

    // Reset in the middle of qualifying bit 3.
    din = 4'b1100;
    repeat (6) step();
    chk("pre_rst_level", 32'(level), 32'(4'b0100));
    rst_n = 1'b0;
    #1;
    chk("in_rst_outs", 32'({level, rise, fall, toggle, tick}), 32'(0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    #1;
    sample();
    chk("post_rst_level", 32'(level), 32'(4'b0000));
    wait_level("rst_requalify", 4'b1000, 4'b1000, 30, ok);
    if (ok) begin
      chk("rst_latency", 32'(cyc), 32'(12));
      chk("rst_level", 32'(level), 32'(4'b1100));
      chk("rst_rise", 32'(rise), 32'(4'b1100));
      step();
      chk("rst_rise_single", 32'(rise), 32'(4'b0000));
      chk("toggle_first", 32'(toggle), 32'(TOG_A));
    end

    // Second press on bit 3.
    din = 4'b0100;
    repeat (20) step();
    chk("press2_release_level", 32'(level), 32'(4'b0100));
    chk("press2_release_toggle", 32'(toggle), 32'(TOG_A));
    din = 4'b1100;
    repeat (20) step();
    chk("press2_level", 32'(level), 32'(4'b1100));
    chk("press2_toggle", 32'(toggle), 32'(TOG_B));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
